imem_loader: RTL and testbench

//  Write-side companion to the instruction memory read port used by the PC fetch path.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Write-side companion to the instruction memory read port. It accepts a
//   byte stream over a valid/ready handshake. The first byte of a load is the
//   word count N. The following 4*N bytes are packed MSB first into 32-bit
//   words. Each word is written to consecutive word addresses, starting at
//   BASE_ADDR. While a load is in progress, cpu_hold keeps the fetch path off
//   the memory.
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     start       begin a load (only looked at while idle)
//     byte_valid  stream byte present
//     byte_data   stream byte
//     byte_ready  loader takes the byte on this edge if byte_valid is high
//     imem_we     one-cycle instruction memory write strobe
//     imem_addr   word-aligned byte address of the word being written
//     imem_wdata  word being written
//     cpu_hold    CPU fetch hold; high for the whole load
//     busy        loader not idle
//     done        one-cycle pulse when all words have been written
//     error       one-cycle pulse when the word count was 0 or too large
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Number of words that fit between BASE_ADDR and the top of memory.
    // Limiting N to this value means the address never wraps during a load.
    localparam int unsigned MAXW = (2 ** (ADDR_WIDTH - 2)) - (BASE_ADDR / 4);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] byte_cnt;      // bytes of the current word already taken
    logic [7:0] words_left;    // words still to be written in this load
    logic       xfer;
    logic       count_bad;

    // byte_ready is a flop, so xfer adds no combinational loop through the source.
    assign xfer      = byte_valid && byte_ready;
    assign count_bad = (byte_data == 8'd0) || ({24'd0, byte_data} > MAXW);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_COUNT;
            S_COUNT: if (xfer)  state_nxt = count_bad ? S_ERR : S_DATA;
            S_DATA:  if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (words_left == 8'd1) ? S_DONE : S_DATA;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The status outputs are registered from the next state. Each one then
    // matches the state it describes, and none of them is decoded
    // combinationally after the flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            byte_ready <= (state_nxt == S_COUNT) || (state_nxt == S_DATA);
            imem_we    <= (state_nxt == S_WRITE);
            cpu_hold   <= (state_nxt != S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
            error      <= (state_nxt == S_ERR);
        end
    end

    // Word assembly. imem_wdata is itself the shift register. After the
    // fourth byte it holds the full big-endian word, and it stays stable
    // through the WRITE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_wdata <= 32'd0;
            byte_cnt   <= 2'd0;
        end else begin
            if (state == S_COUNT && xfer) begin
                byte_cnt <= 2'd0;
            end else if (state == S_DATA && xfer) begin
                imem_wdata <= {imem_wdata[23:0], byte_data};
                byte_cnt   <= byte_cnt + 2'd1;
            end
        end
    end

    // Address and word counter. Both are loaded when the count byte is
    // accepted. Both advance on the cycle after each write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr  <= BASE;
            words_left <= 8'd0;
        end else begin
            if (state == S_COUNT && xfer) begin
                imem_addr  <= BASE;
                words_left <= byte_data;
            end else if (state == S_WRITE) begin
                imem_addr  <= imem_addr + STEP;
                words_left <= words_left - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. Two instances share the byte stream:
//   dut0 uses BASE_ADDR=0x00 (MAXW 64).
//   dut1 uses BASE_ADDR=0x10 (MAXW 60).
// Only the selected instance is started. The other instance sees the stream
// while idle, and it must ignore it.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] bd = 8'd0;

    logic       br0, we0, hold0, busy0, done0, err0;
    logic [7:0] addr0;
    logic [31:0] wd0;
    logic       br1, we1, hold1, busy1, done1, err1;
    logic [7:0] addr1;
    logic [31:0] wd1;

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset(rst_n), .start(start0), .byte_valid(bv), .byte_data(bd),
        .byte_ready(br0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0));

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(16)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .byte_valid(bv), .byte_data(bd),
        .byte_ready(br1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0, inv_bad = 0;
    int sel = 0;

    logic s_br, s_we, s_hold, s_busy, s_done, s_err;
    logic [7:0] s_addr;
    logic [31:0] s_wd;
    assign s_br   = (sel != 0) ? br1   : br0;
    assign s_we   = (sel != 0) ? we1   : we0;
    assign s_hold = (sel != 0) ? hold1 : hold0;
    assign s_busy = (sel != 0) ? busy1 : busy0;
    assign s_done = (sel != 0) ? done1 : done0;
    assign s_err  = (sel != 0) ? err1  : err0;
    assign s_addr = (sel != 0) ? addr1 : addr0;
    assign s_wd   = (sel != 0) ? wd1   : wd0;

    typedef struct { int c; logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t wr_q[$];
    int  done_q[$], err_q[$], hs_q[$];

    // Observation log. It samples on the falling edge, well away from the
    // active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_we) wr_q.push_back('{cyc, s_addr, s_wd});
            if (s_done) done_q.push_back(cyc);
            if (s_err) err_q.push_back(cyc);
            if (s_we && s_br) inv_bad++;
            if (!s_err && (s_busy != s_hold)) inv_bad++;
            if ((sel != 0) ? (we0 || busy0 || br0) : (we1 || busy1 || br1)) inv_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int s);
        wr_q.delete(); done_q.delete(); err_q.delete(); hs_q.delete();
        sel = s;
        if (s != 0) start1 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        chk("start_hold_busy_ready", {s_hold, s_busy, s_br}, 3'b111);
    endtask

    // Present bytes in order. The valid pattern depends on mode:
    //   0 = valid every cycle, 1 = valid on alternate cycles, 2 = random.
    // The handshake edge of each accepted byte is recorded. If start_at is
    // non-negative, start is also pulsed while that byte is on offer.
    task automatic feed(input logic [7:0] q[$], input int mode, input int start_at);
        int idx, budget, e;
        logic acc;
        idx = 0; budget = 0;
        while (idx < q.size() && budget < 3000) begin
            case (mode)
                0:       bv = 1'b1;
                1:       bv = (budget % 2 == 0);
                default: bv = ($urandom_range(0, 2) != 0);
            endcase
            bd = bv ? q[idx] : 8'($urandom);
            if (start_at >= 0 && idx == start_at) begin
                if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
            end
            acc = bv && s_br;
            e = cyc + 1;
            tick();
            start0 = 1'b0; start1 = 1'b0;
            if (acc) begin
                hs_q.push_back(e);
                idx++;
            end
            budget++;
        end
        bv = 1'b0;
        chk("feed_budget", 64'(idx), 64'(q.size()));
    endtask

    // Expected behaviour, derived from the stream alone:
    // - Count 0 or count above maxw: one error pulse in the cycle after the
    //   count handshake, and no writes.
    // - Otherwise: word i goes to base+4i with its four bytes MSB first. The
    //   strobe comes in the cycle after that word's 4th byte handshake, and
    //   done follows the last strobe by one cycle.
    task automatic finish_load(input logic [7:0] q[$], input int base, input int maxw,
                               input string tag);
        int n, w;
        logic [31:0] exp_d;
        n = int'(q[0]);
        w = 0;
        while (done_q.size() == 0 && err_q.size() == 0 && w < 20) begin
            tick();
            w++;
        end
        tick();
        if (n == 0 || n > maxw) begin
            chk({tag, "_err_pulses"}, 64'(err_q.size()), 64'd1);
            chk({tag, "_writes"}, 64'(wr_q.size()), 64'd0);
            chk({tag, "_done_pulses"}, 64'(done_q.size()), 64'd0);
            if (err_q.size() > 0 && hs_q.size() > 0)
                chk({tag, "_err_cycle"}, 64'(err_q[0]), 64'(hs_q[0]));
        end else begin
            chk({tag, "_writes"}, 64'(wr_q.size()), 64'(n));
            chk({tag, "_done_pulses"}, 64'(done_q.size()), 64'd1);
            chk({tag, "_err_pulses"}, 64'(err_q.size()), 64'd0);
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                exp_d = {q[4*i+1], q[4*i+2], q[4*i+3], q[4*i+4]};
                chk($sformatf("%s_addr%0d", tag, i), 64'(wr_q[i].a), 64'((base + 4*i) % 256));
                chk($sformatf("%s_data%0d", tag, i), 64'(wr_q[i].d), 64'(exp_d));
                if (hs_q.size() > 4*i + 4)
                    chk($sformatf("%s_wcyc%0d", tag, i), 64'(wr_q[i].c), 64'(hs_q[4*i+4]));
            end
            if (done_q.size() > 0 && hs_q.size() > 4*n)
                chk({tag, "_done_cycle"}, 64'(done_q[0]), 64'(hs_q[4*n] + 1));
        end
        chk({tag, "_idle_after"}, {s_busy, s_hold, s_br, s_we, s_done, s_err}, 6'b0);
    endtask

    task automatic run_load(input int s, input logic [7:0] q[$], input int mode,
                            input int start_at, input string tag);
        do_start(s);
        feed(q, mode, start_at);
        finish_load(q, (s != 0) ? 16 : 0, (s != 0) ? 60 : 64, tag);
    endtask

    initial begin
        logic [7:0] q[$];
        int n;
        int m;

        // Reset state for both instances.
        tick(); tick();
        chk("rst_ctl0", {br0, we0, hold0, busy0, done0, err0}, 6'b0);
        chk("rst_ctl1", {br1, we1, hold1, busy1, done1, err1}, 6'b0);
        chk("rst_addr0", 64'(addr0), 64'h00);
        chk("rst_addr1", 64'(addr1), 64'h10);
        chk("rst_wdata", {wd0, wd1}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Two-word load with valid held high.
        q = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h00, 8'h07};
        run_load(0, q, 0, -1, "t1");

        // Bad counts: zero, and one above the limit.
        q = '{8'h00};
        run_load(0, q, 0, -1, "t2");
        q = '{8'h41};
        run_load(0, q, 0, -1, "t3a");

        // Largest legal load: 64 words, the last one at 0xFC.
        q.delete();
        q.push_back(8'h40);
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        run_load(0, q, 2, -1, "t3b");

        // Valid toggling every cycle.
        q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(0, q, 1, -1, "t4");

        // Reset after two data bytes of the first word.
        do_start(0);
        q = '{8'h01, 8'hAA, 8'hBB};
        feed(q, 0, -1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ctl", {br0, we0, hold0, busy0, done0, err0}, 6'b0);
        chk("t5_rst_addr_data", {addr0, wd0}, 40'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t5_no_partial_write", 64'(wr_q.size()), 64'd0);
        q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(0, q, 0, -1, "t5");

        // Valid high while idle is not taken.
        sel = 0;
        bv = 1'b1; bd = 8'h03;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_idle_ignore", {br0, busy0, hold0}, 3'b0);
        end
        bv = 1'b0;

        // A start pulse during DATA changes nothing.
        q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(0, q, 0, 3, "t6a");

        // Non-zero base address; the limit there is 60 words.
        q = '{8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_load(1, q, 0, -1, "t6b");
        q = '{8'd61};
        run_load(1, q, 0, -1, "t6c");

        // Random legal and illegal loads on both instances.
        for (int r = 0; r < 8; r++) begin
            m = (r % 2 != 0) ? 60 : 64;
            q.delete();
            if (r % 4 == 3) begin
                n = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(m + 1, 255);
                q.push_back(8'(n));
            end else begin
                n = $urandom_range(1, 6);
                q.push_back(8'(n));
                for (int i = 0; i < 4*n; i++) q.push_back(8'($urandom));
            end
            run_load(r % 2, q, 2, (r == 4) ? 2 : -1, $sformatf("rnd%0d", r));
        end

        chk("invariants", 64'(inv_bad), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
